// File: rtl/reset_sequencer.sv
// Staged reset generator: all stages assert together on reset or trigger, then
// release one at a time in index order; also tracks last cause and trigger count.
module reset_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int PULSE_LEN  = 16,
    parameter int STAGE_GAP  = 4,
    parameter int DEBOUNCE   = 8
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  rst_req,
    input  logic                  btn_n,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  busy,
    output logic [1:0]            last_cause,
    output logic [7:0]            req_count
);

    localparam int HW = $clog2(PULSE_LEN + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int SW = $clog2(NUM_STAGES + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(PULSE_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [HW-1:0]           hold_cnt_reg, hold_cnt_next;
    logic [GW-1:0]           gap_cnt_reg, gap_cnt_next;
    logic [SW-1:0]           stage_idx_reg, stage_idx_next;
    logic [NUM_STAGES-1:0]   rst_out_reg, rst_out_next;
    logic                    busy_reg, busy_next;
    logic [1:0]              last_cause_reg, last_cause_next;
    logic [7:0]              req_count_reg, req_count_next;

    logic                    sync1_reg, sync2_reg;
    logic                    btn_state_reg;
    logic [DW-1:0]           deb_cnt_reg;
    logic                    btn_press_reg;
    logic                    trig;

    // Button path: 2-flop synchronizer, then a stability counter that flips the
    // debounced state only after DEBOUNCE matching samples; a press strobes once.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            btn_state_reg <= 1'b1;
            deb_cnt_reg   <= '0;
            btn_press_reg <= 1'b0;
        end else begin
            sync1_reg     <= btn_n;
            sync2_reg     <= sync1_reg;
            btn_press_reg <= 1'b0;
            if (sync2_reg == btn_state_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                btn_state_reg <= sync2_reg;
                deb_cnt_reg   <= '0;
                btn_press_reg <= ~sync2_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DW'(1);
            end
        end
    end

    assign trig = rst_req | btn_press_reg;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_reg      <= ASSERT;
            hold_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            stage_idx_reg  <= '0;
            rst_out_reg    <= '1;
            busy_reg       <= 1'b1;
            last_cause_reg <= 2'b00;
            req_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            stage_idx_reg  <= stage_idx_next;
            rst_out_reg    <= rst_out_next;
            busy_reg       <= busy_next;
            last_cause_reg <= last_cause_next;
            req_count_reg  <= req_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        stage_idx_next  = stage_idx_reg;
        rst_out_next    = rst_out_reg;
        busy_next       = busy_reg;
        last_cause_next = last_cause_reg;
        req_count_next  = req_count_reg;

        if (trig) begin
            state_next      = ASSERT;
            hold_cnt_next   = '0;
            gap_cnt_next    = '0;
            stage_idx_next  = '0;
            rst_out_next    = '1;
            busy_next       = 1'b1;
            last_cause_next = {btn_press_reg, rst_req};
            if (req_count_reg != 8'hFF) begin
                req_count_next = req_count_reg + 8'd1;
            end
        end else begin
            case (state_reg)
                ASSERT: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        // Ones always form a run from the MSB down, so a left
                        // shift releases exactly the lowest asserted stage.
                        rst_out_next   = rst_out_reg << 1;
                        stage_idx_next = SW'(1);
                        gap_cnt_next   = '0;
                        if (NUM_STAGES == 1) begin
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end else begin
                            state_next = RELEASE;
                        end
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        rst_out_next   = rst_out_reg << 1;
                        stage_idx_next = stage_idx_reg + SW'(1);
                        gap_cnt_next   = '0;
                        if (stage_idx_reg == STAGE_LAST) begin
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end
                    end else begin
                        gap_cnt_next = gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_rst_out
            assign rst_out[gi] = rst_out_reg[gi];
        end
    endgenerate

    assign busy       = busy_reg;
    assign last_cause = last_cause_reg;
    assign req_count  = req_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a timeline model (edges since last
// reset/trigger) is compared every cycle, plus hand-computed literal checks.
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int PL = 16;
    localparam int SG = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          sync_reset = 1'b1;
    logic          rst_req = 1'b0;
    logic          btn_n = 1'b1;
    logic [NS-1:0] rst_out;
    logic          busy;
    logic [1:0]    last_cause;
    logic [7:0]    req_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES(NS),
        .PULSE_LEN (PL),
        .STAGE_GAP (SG),
        .DEBOUNCE  (DB)
    ) dut (
        .clk       (clk),
        .sync_reset(sync_reset),
        .rst_req   (rst_req),
        .btn_n     (btn_n),
        .rst_out   (rst_out),
        .busy      (busy),
        .last_cause(last_cause),
        .req_count (req_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: outputs follow from the number of edges elapsed since
    // the last reset or trigger; the button is modelled as sample run lengths.
    int         m_elapsed = 0;
    logic [1:0] m_cause = 2'b00;
    int         m_count = 0;
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_db = 1'b1;
    int         m_run = 0;
    logic       m_press = 1'b0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        logic v;
        logic t;
        v = m_s2;
        if (sync_reset) begin
            m_elapsed = 0;
            m_cause   = 2'b00;
            m_count   = 0;
            m_s1      = 1'b1;
            m_s2      = 1'b1;
            m_db      = 1'b1;
            m_run     = 0;
            m_press   = 1'b0;
        end else begin
            t = rst_req | m_press;
            if (t) begin
                m_elapsed = 0;
                m_cause   = {m_press, rst_req};
                if (m_count < 255) m_count++;
            end else if (m_elapsed < 100000) begin
                m_elapsed++;
            end
            m_press = 1'b0;
            if (v != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db    = v;
                    m_run   = 0;
                    m_press = (v == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_n;
        end
        m_valid = 1'b1;
    end

    function automatic int released_stages(input int elapsed);
        int r;
        if (elapsed < PL) r = 0;
        else r = 1 + (elapsed - PL) / SG;
        if (r > NS) r = NS;
        return r;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            logic [NS-1:0] exp_out;
            int rel;
            rel = released_stages(m_elapsed);
            exp_out = '1;
            exp_out = exp_out << rel;
            check("cyc rst_out", 32'(rst_out), 32'(exp_out));
            check("cyc busy", 32'(busy), 32'(rel < NS));
            check("cyc last_cause", 32'(last_cause), 32'(m_cause));
            check("cyc req_count", 32'(req_count), 32'(m_count));
        end
    end

    initial begin
        // Power-on reset, then release sequence at edges 16/20/24
        tick(5);
        check("rst rst_out", 32'(rst_out), 32'h7);
        check("rst busy", 32'(busy), 32'h1);
        check("rst cause", 32'(last_cause), 32'h0);
        check("rst count", 32'(req_count), 32'h0);
        sync_reset = 1'b0;
        tick(15);
        check("por edge15", 32'(rst_out), 32'h7);
        tick(1);
        check("por edge16", 32'(rst_out), 32'h6);
        tick(4);
        check("por edge20", 32'(rst_out), 32'h4);
        tick(4);
        check("por edge24", 32'(rst_out), 32'h0);
        check("por busy24", 32'(busy), 32'h0);
        tick(3);

        // Software request from IDLE
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        check("req assert", 32'(rst_out), 32'h7);
        check("req cause", 32'(last_cause), 32'h1);
        check("req count", 32'(req_count), 32'h1);
        tick(16);
        check("req +16", 32'(rst_out), 32'h6);

        // Request during RELEASE re-asserts everything
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        check("rel reassert", 32'(rst_out), 32'h7);
        check("rel count", 32'(req_count), 32'h2);
        tick(16);
        check("rel +16", 32'(rst_out), 32'h6);
        tick(8);
        check("rel +24", 32'(rst_out), 32'h0);

        // Bouncing button, then a clean press held long
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0;
            tick(3);
            btn_n = 1'b1;
            tick(2);
        end
        btn_n = 1'b0;
        tick(10);
        check("btn before", 32'(req_count), 32'h2);
        tick(1);
        check("btn press", 32'(req_count), 32'h3);
        check("btn cause", 32'(last_cause), 32'h2);
        check("btn assert", 32'(rst_out), 32'h7);
        tick(50);
        check("btn held", 32'(req_count), 32'h3);
        btn_n = 1'b1;
        tick(20);

        // Request and button strobe on the same edge
        btn_n = 1'b0;
        tick(10);
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        check("both cause", 32'(last_cause), 32'h3);
        check("both count", 32'(req_count), 32'h4);
        btn_n = 1'b1;
        tick(20);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            rst_req = 1'b1;
            tick(1);
            rst_req = 1'b0;
            tick(1);
        end
        check("sat count", 32'(req_count), 32'hFF);
        check("sat cause", 32'(last_cause), 32'h1);

        // sync_reset mid-sequence
        sync_reset = 1'b1;
        tick(2);
        sync_reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rst_req = 1'b1;
            tick(1);
            rst_req = 1'b0;
            if (i < 6) tick(1);
        end
        tick(20);
        check("mid rst_out", 32'(rst_out), 32'h4);
        check("mid count", 32'(req_count), 32'h7);
        sync_reset = 1'b1;
        tick(1);
        check("mid rst rst_out", 32'(rst_out), 32'h7);
        check("mid rst busy", 32'(busy), 32'h1);
        check("mid rst count", 32'(req_count), 32'h0);
        check("mid rst cause", 32'(last_cause), 32'h0);
        sync_reset = 1'b0;
        tick(24);
        check("mid done", 32'(rst_out), 32'h0);
        check("mid busy", 32'(busy), 32'h0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
